pos_logic_unit: RTL and testbench

// - Parametrised, registered successor of the 16-bit bitwise OR: a WIDTH-bit bitwise logic unit with eight selectable ops.
// - Adds an accumulator mode (B replaced by the running result), result flags, and a valid/ready handshake on both sides.
// - Sits in the ALU datapath beside the adder and shifter. The ALU mux consumes OUT and the flags one cycle after a beat is accepted.
//

---
 rtl/alu_pkg.sv | 22 ++
 rtl/pos_logic_core.sv | 27 ++
 rtl/pos_logic_unit.sv | 92 +++++++++
 tb/tb_pos_logic_unit.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: logic-unit opcodes, default datapath width and the
// flag bit positions used by the adder/shifter/logic flag merge.
package alu_pkg;

  localparam int ALU_WIDTH = 16;

  localparam logic [2:0] OP_OR    = 3'b000;
  localparam logic [2:0] OP_AND   = 3'b001;
  localparam logic [2:0] OP_XOR   = 3'b010;
  localparam logic [2:0] OP_NOR   = 3'b011;
  localparam logic [2:0] OP_NAND  = 3'b100;
  localparam logic [2:0] OP_XNOR  = 3'b101;
  localparam logic [2:0] OP_ANDN  = 3'b110;
  localparam logic [2:0] OP_PASSA = 3'b111;

  // Bit positions inside the packed flag vector.
  localparam int FLAG_W     = 3;
  localparam int FLAG_Z_BIT = 0;
  localparam int FLAG_N_BIT = 1;
  localparam int FLAG_P_BIT = 2;

endpackage

// File: rtl/pos_logic_core.sv
// Combinational bitwise operation selector: result = f(a, b) chosen by op.
module pos_logic_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] res
);

  always_comb begin
    res = a;
    case (op)
      OP_OR:    res = a | b;
      OP_AND:   res = a & b;
      OP_XOR:   res = a ^ b;
      OP_NOR:   res = ~(a | b);
      OP_NAND:  res = ~(a & b);
      OP_XNOR:  res = ~(a ^ b);
      OP_ANDN:  res = a & ~b;
      OP_PASSA: res = a;
    endcase
  end

endmodule

// File: rtl/pos_logic_unit.sv
// Registered WIDTH-bit logic unit with accumulator mode, result flags and a
// single-entry output register behind a valid/ready handshake.
module pos_logic_unit
  import alu_pkg::*;
#(
  parameter int               WIDTH    = ALU_WIDTH,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc,
  input  logic             clr_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_p
);

  // Handshake: a beat transfers on a side when valid && ready in the same
  // cycle; valid never depends on ready, and a held result (valid && !ready)
  // keeps out/flags stable and blocks the input side.
  logic              accept;
  logic [WIDTH-1:0]  acc_q;
  logic [WIDTH-1:0]  acc_src;
  logic [WIDTH-1:0]  beff;
  logic [WIDTH-1:0]  res;
  logic [WIDTH-1:0]  out_q;
  logic              valid_q;
  logic [FLAG_W-1:0] flags_q;
  logic [FLAG_W-1:0] flags_d;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // A same-cycle clear is seen by an accumulating beat before it is used.
  assign acc_src = clr_acc ? ACC_INIT : acc_q;
  assign beff    = acc ? acc_src : b;

  pos_logic_core #(.WIDTH(WIDTH)) u_core (
    .a   (a),
    .b   (beff),
    .op  (op),
    .res (res)
  );

  always_comb begin
    flags_d             = '0;
    flags_d[FLAG_Z_BIT] = (res == '0);
    flags_d[FLAG_N_BIT] = res[WIDTH-1];
    flags_d[FLAG_P_BIT] = ^res;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q               <= '0;
      valid_q             <= 1'b0;
      flags_q             <= '0;
      flags_q[FLAG_Z_BIT] <= 1'b1;
    end else if (accept) begin
      out_q   <= res;
      valid_q <= 1'b1;
      flags_q <= flags_d;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  // Accumulating beat beats the clear: its Beff already used the cleared value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= ACC_INIT;
    end else if (accept && acc) begin
      acc_q <= res;
    end else if (clr_acc) begin
      acc_q <= ACC_INIT;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign flag_z    = flags_q[FLAG_Z_BIT];
  assign flag_n    = flags_q[FLAG_N_BIT];
  assign flag_p    = flags_q[FLAG_P_BIT];

endmodule

// File: tb/tb_pos_logic_unit.sv
// Self-checking bench for pos_logic_unit: directed scenarios plus a random
// stream compared against a queue-based reference model.
module tb_pos_logic_unit;

  localparam int          W    = 16;
  localparam logic [W-1:0] INIT = '0;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   op = '0;
  logic         acc = 1'b0;
  logic         clr_acc = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out;
  logic         flag_z;
  logic         flag_n;
  logic         flag_p;

  // Reference model state
  logic [W-1:0] acc_m;
  logic [W-1:0] out_m;
  logic [W-1:0] exp_q[$];
  int           n_vec = 0;
  int           n_err = 0;

  always #5 clk = ~clk;

  pos_logic_unit #(.WIDTH(W), .ACC_INIT(INIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .acc       (acc),
    .clr_acc   (clr_acc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_p    (flag_p)
  );

  function automatic logic [W-1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic [2:0] o);
    logic [W-1:0] r;
    r = x;
    case (o)
      3'd0: r = x | y;
      3'd1: r = x & y;
      3'd2: r = x ^ y;
      3'd3: r = ~(x | y);
      3'd4: r = ~(x & y);
      3'd5: r = ~(x ^ y);
      3'd6: r = x & ~y;
      3'd7: r = x;
    endcase
    return r;
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [2:0] ov, input logic accv, input logic clrv,
                       input logic rdy);
    in_valid  = v;
    a         = av;
    b         = bv;
    op        = ov;
    acc       = accv;
    clr_acc   = clrv;
    out_ready = rdy;
  endtask

  // Advances one clock; the model reacts to the inputs present at the edge.
  task automatic tick();
    logic         held;
    logic         acpt;
    logic [W-1:0] beff;
    logic [W-1:0] r;
    held = (exp_q.size() != 0);
    acpt = in_valid && (!held || out_ready);
    beff = acc ? (clr_acc ? INIT : acc_m) : b;
    r    = ref_op(a, beff, op);
    if (held && out_ready) void'(exp_q.pop_front());
    if (acpt) begin
      exp_q.push_back(r);
      out_m = r;
    end
    if (acpt && acc) acc_m = r;
    else if (clr_acc) acc_m = INIT;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    n_vec++;
    if (out !== 16'h0000 || flag_z !== 1'b1 || flag_n !== 1'b0 || flag_p !== 1'b0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_por: out=%h z=%b n=%b p=%b v=%b, want 0000 1 0 0 0", out, flag_z, flag_n, flag_p, out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    acc_m = INIT;
    out_m = '0;
    exp_q.delete();
    drive(1'b1, 16'h1234, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1 || out !== 16'h1234) begin
      n_err++;
      $display("FAIL reset_prefill: out=%h v=%b, want 1234 1", out, out_valid);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (out !== 16'h0000 || flag_z !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async: out=%h z=%b v=%b, want 0000 1 0", out, flag_z, out_valid);
    end
    #1 rst = 1'b0;
    acc_m = INIT;
    out_m = '0;
    exp_q.delete();
    out_ready = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_all_ops();
    logic [W-1:0] want[8];
    want = '{16'hFFF0, 16'hF000, 16'h0FF0, 16'h000F, 16'h0FFF, 16'hF00F, 16'h00F0, 16'hF0F0};
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'hF0F0, 16'hFF00, 3'(i), 1'b0, 1'b0, 1'b1);
      tick();
      n_vec++;
      if (out !== want[i] || out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL op_%0d: out=%h v=%b, want %h 1", i, out, out_valid, want[i]);
      end
      if (i == 3) begin
        n_vec++;
        if (flag_n !== 1'b0 || flag_p !== 1'b0 || flag_z !== 1'b0) begin
          n_err++;
          $display("FAIL nor_flags: z=%b n=%b p=%b, want 0 0 0", flag_z, flag_n, flag_p);
        end
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_accumulate();
    logic [W-1:0] av[3];
    logic [W-1:0] want[3];
    av   = '{16'h0001, 16'h0100, 16'h8000};
    want = '{16'h0001, 16'h0101, 16'h8101};
    drive(1'b0, '0, '0, 3'd0, 1'b0, 1'b1, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, av[i], 16'hFFFF, 3'd0, 1'b1, 1'b0, 1'b1);
      tick();
      n_vec++;
      if (out !== want[i]) begin
        n_err++;
        $display("FAIL acc_beat_%0d: out=%h want %h", i, out, want[i]);
      end
    end
    n_vec++;
    if (flag_n !== 1'b1 || flag_p !== 1'b1 || flag_z !== 1'b0) begin
      n_err++;
      $display("FAIL acc_flags: z=%b n=%b p=%b, want 0 1 1", flag_z, flag_n, flag_p);
    end
    drive(1'b1, 16'h1234, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b1);
    tick();
    n_vec++;
    if (out !== 16'h1234) begin
      n_err++;
      $display("FAIL acc_bypass: out=%h want 1234", out);
    end
    drive(1'b1, 16'h0000, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b1);
    tick();
    n_vec++;
    if (out !== 16'h8101) begin
      n_err++;
      $display("FAIL acc_untouched: out=%h want 8101", out);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    drive(1'b1, 16'h5555, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h0002, 16'h0000, 3'd2, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_in_ready_%0d: got %b want 0", i, in_ready);
      end
      tick();
      n_vec++;
      if (out !== 16'h5555 || out_valid !== 1'b1 || flag_z !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold_%0d: out=%h v=%b want 5555 1", i, out, out_valid);
      end
    end
    out_ready = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release_ready: got %b want 1", in_ready);
    end
    tick();
    n_vec++;
    if (out !== 16'h8103 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL bp_accept: out=%h v=%b want 8103 1", out, out_valid);
    end
    in_valid = 1'b0;
    tick();
    n_vec++;
    if (out_valid !== 1'b0 || out !== 16'h8103) begin
      n_err++;
      $display("FAIL bp_drain: out=%h v=%b want 8103 0", out, out_valid);
    end
    drive(1'b1, 16'h0000, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b1);
    tick();
    n_vec++;
    if (out !== 16'h8103) begin
      n_err++;
      $display("FAIL bp_acc_once: out=%h want 8103", out);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_clr_priority();
    drive(1'b1, 16'h00FF, 16'h0000, 3'd0, 1'b1, 1'b1, 1'b1);
    tick();
    drive(1'b1, 16'h0F00, 16'h0000, 3'd0, 1'b1, 1'b1, 1'b1);
    tick();
    n_vec++;
    if (out !== 16'h0F00) begin
      n_err++;
      $display("FAIL clr_acc_beat: out=%h want 0f00", out);
    end
    drive(1'b1, 16'h0000, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b1);
    tick();
    n_vec++;
    if (out !== 16'h0F00) begin
      n_err++;
      $display("FAIL clr_acc_wins: out=%h want 0f00", out);
    end
    drive(1'b1, 16'h0001, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h00AA, 16'h0000, 3'd0, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 16'h0000, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b1);
    tick();
    n_vec++;
    if (out !== 16'h0000 || flag_z !== 1'b1) begin
      n_err++;
      $display("FAIL clr_stalled: out=%h z=%b want 0000 1", out, flag_z);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic         prev_hold;
    logic [W-1:0] prev_out;
    logic [W-1:0] h;
    prev_hold = 1'b0;
    prev_out  = '0;
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 3) != 0));
      #1;
      n_vec++;
      if (in_ready !== (exp_q.size() == 0 || out_ready) || out_valid !== (exp_q.size() != 0)) begin
        n_err++;
        $display("FAIL rnd_hs_%0d: in_ready=%b out_valid=%b, want %b %b", i, in_ready, out_valid,
                 (exp_q.size() == 0 || out_ready), (exp_q.size() != 0));
      end
      if (exp_q.size() != 0) begin
        h = exp_q[0];
        n_vec++;
        if (out !== h || flag_z !== (h == '0) || flag_n !== h[W-1] || flag_p !== 1'($countones(h) % 2)) begin
          n_err++;
          $display("FAIL rnd_data_%0d: out=%h z=%b n=%b p=%b, want %h", i, out, flag_z, flag_n, flag_p, h);
        end
      end
      if (prev_hold) begin
        n_vec++;
        if (out !== prev_out) begin
          n_err++;
          $display("FAIL rnd_stable_%0d: out=%h want %h", i, out, prev_out);
        end
      end
      prev_hold = (exp_q.size() != 0) && !out_ready;
      prev_out  = out;
      tick();
    end
    drive(1'b0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b1);
    tick();
    n_vec++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL rnd_drain: out_valid=%b pending=%0d, want 0 0", out_valid, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_all_ops();
    test_accumulate();
    test_backpressure();
    test_clr_priority();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
